// File: rtl/param_register_file_if.sv
// rtl/param_register_file_if.sv - data, select and flush handshake bundle for param_register_file
interface param_register_file_if #(
  parameter int WIDTH = 16,
  parameter int NGP   = 4,
  parameter int NSCR  = 4
) ();
  localparam int SELW = (NGP + NSCR) > 1 ? $clog2(NGP + NSCR) : 1;

  logic [WIDTH-1:0] I;
  logic [SELW-1:0]  OutASel;
  logic [SELW-1:0]  OutBSel;
  logic [2:0]       FunSel;
  logic [NGP-1:0]   RegSel;
  logic [NSCR-1:0]  ScrSel;
  logic             FlushReq;
  logic             Busy;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;

  modport master (
    output I, OutASel, OutBSel, FunSel, RegSel, ScrSel, FlushReq,
    input  Busy, OutA, OutB
  );

  modport slave (
    input  I, OutASel, OutBSel, FunSel, RegSel, ScrSel, FlushReq,
    output Busy, OutA, OutB
  );
endinterface

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - GP + scratch register file with shared function unit, bypass and sequenced flush
module param_register_file #(
  parameter int WIDTH  = 16,
  parameter int NGP    = 4,
  parameter int NSCR   = 4,
  parameter bit BYPASS = 1'b0
) (
  input logic                  Clock,
  input logic                  Reset,
  param_register_file_if.slave bus
);
  localparam int N    = NGP + NSCR;
  localparam int SELW = N > 1 ? $clog2(N) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state;
  logic [SELW-1:0]  flush_cnt;
  logic             busy_q;
  logic [WIDTH-1:0] regs [N];
  logic [N-1:0]     sel_n;
  logic [N-1:0]     wr_en;
  logic             byp_ok;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;

  // Linear index 0 is R1 and NGP is S1, while the enable buses put R1/S1 on their MSBs.
  assign sel_n = {bus.RegSel, bus.ScrSel};

  // Flip the concatenated active-low enables into linear-index order.
  always_comb begin
    wr_en = '0;
    for (int k = 0; k < N; k++) begin
      wr_en[k] = ~sel_n[N-1-k];
    end
  end

  function automatic logic [WIDTH-1:0] apply_fun(input logic [2:0]       f,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    case (f)
      3'b000:  r = q - WIDTH'(1);
      3'b001:  r = q + WIDTH'(1);
      3'b010:  r = d;
      3'b011:  r = '0;
      3'b100:  r = q << 1;
      3'b101:  r = q >> 1;
      3'b110:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      default: r = q;
    endcase
    return r;
  endfunction

  // Register updates and flush sequencing; a flush owns the file and locks out normal writes.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < N; k++) begin
        regs[k] <= '0;
      end
      state     <= IDLE;
      flush_cnt <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          for (int k = 0; k < N; k++) begin
            if (wr_en[k]) begin
              regs[k] <= apply_fun(bus.FunSel, regs[k], bus.I);
            end
          end
          if (bus.FlushReq) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end
        FLUSH: begin
          for (int k = 0; k < N; k++) begin
            if (flush_cnt == SELW'(k)) begin
              regs[k] <= '0;
            end
          end
          if (flush_cnt == SELW'(N - 1)) begin
            state     <= IDLE;
            flush_cnt <= '0;
            busy_q    <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + SELW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Only a load in IDLE forwards I; every other function shows the stored value.
  assign byp_ok = BYPASS && (state == IDLE) && (bus.FunSel == 3'b010);

  // Combinational read ports; selects past the last register read as zero.
  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.OutASel == SELW'(k)) begin
        out_a = (byp_ok && wr_en[k]) ? bus.I : regs[k];
      end
      if (bus.OutBSel == SELW'(k)) begin
        out_b = (byp_ok && wr_en[k]) ? bus.I : regs[k];
      end
    end
  end

  assign bus.OutA = out_a;
  assign bus.OutB = out_b;
  assign bus.Busy = busy_q;
endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - directed self-checking bench for param_register_file
module tb_param_register_file;
  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   failures = 0;
  int   busy_cycles;

  always #5 Clock = ~Clock;

  param_register_file_if #(.WIDTH(16), .NGP(4), .NSCR(4)) d_if ();
  param_register_file_if #(.WIDTH(16), .NGP(4), .NSCR(4)) b_if ();
  param_register_file_if #(.WIDTH(16), .NGP(3), .NSCR(2)) s_if ();

  param_register_file #(.WIDTH(16), .NGP(4), .NSCR(4), .BYPASS(1'b0)) u_d (
    .Clock(Clock), .Reset(Reset), .bus(d_if.slave));
  param_register_file #(.WIDTH(16), .NGP(4), .NSCR(4), .BYPASS(1'b1)) u_b (
    .Clock(Clock), .Reset(Reset), .bus(b_if.slave));
  param_register_file #(.WIDTH(16), .NGP(3), .NSCR(2), .BYPASS(1'b0)) u_s (
    .Clock(Clock), .Reset(Reset), .bus(s_if.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Same stimulus to both 4+4 instances.
  task automatic drv(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] fs,
                     input logic [15:0] di, input logic fr);
    d_if.RegSel = rs; d_if.ScrSel = ss; d_if.FunSel = fs; d_if.I = di; d_if.FlushReq = fr;
    b_if.RegSel = rs; b_if.ScrSel = ss; b_if.FunSel = fs; b_if.I = di; b_if.FlushReq = fr;
  endtask

  task automatic idle();
    drv(4'hF, 4'hF, 3'b111, 16'h0000, 1'b0);
  endtask

  task automatic sel(input logic [2:0] a, input logic [2:0] b);
    d_if.OutASel = a; d_if.OutBSel = b;
    b_if.OutASel = a; b_if.OutBSel = b;
    #1;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic s_idle();
    s_if.RegSel = 3'b111; s_if.ScrSel = 2'b11; s_if.FunSel = 3'b111;
    s_if.I = 16'h0000; s_if.FlushReq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    idle();
    s_idle();
    s_if.OutASel = 3'd0; s_if.OutBSel = 3'd0;
    sel(3'd0, 3'd7);
    step();
    chk("reset_outa", d_if.OutA, 16'h0000);
    chk("reset_outb", d_if.OutB, 16'h0000);
    chk("reset_busy", d_if.Busy, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;

    // Load R1..R4 with 0x1234; small instance loads every register with 0x7777
    drv(4'b0000, 4'hF, 3'b010, 16'h1234, 1'b0);
    s_if.RegSel = 3'b000; s_if.ScrSel = 2'b00; s_if.FunSel = 3'b010; s_if.I = 16'h7777;
    step();
    idle();
    s_idle();
    sel(3'd0, 3'd3);
    chk("load_r1", d_if.OutA, 16'h1234);
    chk("load_r4", d_if.OutB, 16'h1234);
    sel(3'd4, 3'd7);
    chk("load_s1_untouched", d_if.OutA, 16'h0000);
    chk("load_s4_untouched", d_if.OutB, 16'h0000);

    // Small instance: in-range and out-of-range selects
    s_if.OutASel = 3'd0; #1;
    chk("small_r1", s_if.OutA, 16'h7777);
    s_if.OutASel = 3'd4; #1;
    chk("small_s2", s_if.OutA, 16'h7777);
    for (int v = 5; v < 8; v++) begin
      s_if.OutASel = 3'(v); #1;
      chk("small_oor", s_if.OutA, 16'h0000);
    end

    // Wrap-around on R1
    drv(4'b0111, 4'hF, 3'b011, 16'h0000, 1'b0);
    step();
    drv(4'b0111, 4'hF, 3'b000, 16'h0000, 1'b0);
    step();
    idle();
    sel(3'd0, 3'd1);
    chk("dec_wrap_r1", d_if.OutA, 16'hFFFF);
    chk("dec_wrap_r2", d_if.OutB, 16'h1234);
    drv(4'b0111, 4'hF, 3'b001, 16'h0000, 1'b0);
    step();
    idle();
    sel(3'd0, 3'd3);
    chk("inc_wrap_r1", d_if.OutA, 16'h0000);
    chk("inc_wrap_r4", d_if.OutB, 16'h1234);

    // Shifts and rotate on R1
    drv(4'b0111, 4'hF, 3'b010, 16'h8001, 1'b0);
    step();
    drv(4'b0111, 4'hF, 3'b110, 16'h0000, 1'b0);
    step();
    idle();
    sel(3'd0, 3'd1);
    chk("rotl_r1", d_if.OutA, 16'h0003);
    chk("rotl_r2", d_if.OutB, 16'h1234);
    drv(4'b0111, 4'hF, 3'b100, 16'h0000, 1'b0);
    step();
    idle();
    sel(3'd0, 3'd0);
    chk("shl_r1", d_if.OutA, 16'h0006);
    drv(4'b0111, 4'hF, 3'b101, 16'h0000, 1'b0);
    step();
    idle();
    sel(3'd0, 3'd0);
    chk("shr_r1", d_if.OutA, 16'h0003);

    // Bypass: S1 loaded with 0xBEEF, observed before the edge
    @(negedge Clock);
    drv(4'hF, 4'b0111, 3'b010, 16'hBEEF, 1'b0);
    sel(3'd4, 3'd5);
    chk("bypass_on_s1", b_if.OutA, 16'hBEEF);
    chk("bypass_off_s1", d_if.OutA, 16'h0000);
    chk("bypass_unenabled_s2", b_if.OutB, 16'h0000);
    step();
    idle();
    sel(3'd4, 3'd4);
    chk("after_edge_s1_d", d_if.OutA, 16'hBEEF);
    chk("after_edge_s1_b", b_if.OutA, 16'hBEEF);

    // Flush: fill with 0x00AA, then pulse FlushReq
    drv(4'b0000, 4'b0000, 3'b010, 16'h00AA, 1'b0);
    step();
    idle();
    sel(3'd0, 3'd7);
    chk("fill_r1", d_if.OutA, 16'h00AA);
    chk("fill_s4", d_if.OutB, 16'h00AA);
    @(negedge Clock);
    drv(4'hF, 4'hF, 3'b111, 16'h0000, 1'b1);
    step();
    drv(4'b0000, 4'b0000, 3'b010, 16'h5555, 1'b0);
    busy_cycles = 0;
    if (d_if.Busy) busy_cycles++;
    for (int c = 1; c < 20; c++) begin
      step();
      if (c == 3) begin
        sel(3'd0, 3'd2);
        chk("mid_flush_r1", d_if.OutA, 16'h0000);
        chk("mid_flush_r3", d_if.OutB, 16'h0000);
        sel(3'd3, 3'd1);
        chk("mid_flush_r4", d_if.OutA, 16'h00AA);
        chk("mid_flush_r2", d_if.OutB, 16'h0000);
        chk("mid_flush_no_bypass", b_if.OutA, 16'h00AA);
      end
      if (d_if.Busy) busy_cycles++;
      else break;
    end
    idle();
    chk("flush_busy_cycles", busy_cycles, 8);
    chk("flush_busy_low", d_if.Busy, 1'b0);
    for (int k = 0; k < 8; k++) begin
      sel(3'(k), 3'(k));
      chk("flush_cleared_d", d_if.OutA, 16'h0000);
      chk("flush_cleared_b", b_if.OutB, 16'h0000);
    end

    // Write with FlushReq at one edge, then asynchronous abort in flush cycle 2
    @(negedge Clock);
    drv(4'b0000, 4'b0000, 3'b010, 16'h00AA, 1'b1);
    step();
    idle();
    sel(3'd7, 3'd4);
    chk("flushreq_write_s4", d_if.OutA, 16'h00AA);
    chk("flushreq_write_s1", d_if.OutB, 16'h00AA);
    chk("flushreq_busy", d_if.Busy, 1'b1);
    s_if.OutASel = 3'd0;
    step();
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_busy", d_if.Busy, 1'b0);
    chk("abort_s4", d_if.OutA, 16'h0000);
    chk("abort_s1", d_if.OutB, 16'h0000);
    chk("abort_small_r1", s_if.OutA, 16'h0000);
    @(negedge Clock);
    Reset = 1'b0;
    step();
    chk("post_abort_busy", d_if.Busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
